// File: rtl/char_uart_tx.sv
// char_uart_tx: buffers the ASCII character stream in a small FIFO and
// serialises it onto an 8N1 UART line, LSB first. Characters that arrive
// while the FIFO is full are dropped and flagged with a sticky overflow bit.
module char_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FIFO_AW      = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               char_vld,
  input  logic [7:0]         char_data,
  output logic               uart_tx,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic               pop_c;
  logic               wr_en_c;
  logic               baud_wrap_c;

  logic [7:0] mem [FIFO_DEPTH];

  // Next-state logic for the transmitter FSM, FIFO bookkeeping and line value
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pop_c       = 1'b0;
    baud_wrap_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_wrap_c) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_wrap_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        if (baud_wrap_c) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase

    // A full FIFO still accepts a write when the same cycle frees a slot
    wr_en_c    = char_vld && ((level_q < LVL_W'(FIFO_DEPTH)) || pop_c);
    overflow_d = overflow_q || (char_vld && !wr_en_c);
    level_d    = level_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    wr_ptr_d   = wr_en_c ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_c ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;

    // Line value is precomputed so the output flop tracks the state register
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[bit_d];
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) || (level_d != '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= char_data;
    end
  end

  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_char_uart_tx.sv
// Testbench for char_uart_tx: directed scenarios plus random bursts, checked
// cycle by cycle against a frame-timing reference model.
module tb_char_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        char_vld;
  logic [7:0]  char_data;
  logic        uart_tx;
  logic        busy;
  logic        overflow;
  logic [AW:0] fifo_level;

  always #5 clk = ~clk;

  char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_vld   (char_vld),
    .char_data  (char_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int peak     = 0;

  // Reference model: queued chars plus the start cycle of the frame in flight
  int         t      = 0;
  logic [7:0] q[$];
  bit         act    = 1'b0;
  int         fstart = 0;
  logic [7:0] fbyte  = 8'h00;
  bit         movf   = 1'b0;

  function automatic bit in_frame();
    return act && (t < fstart + FRAME);
  endfunction

  function automatic bit m_busy();
    return in_frame() || (q.size() != 0);
  endfunction

  function automatic logic m_tx();
    int slot;
    if (!in_frame()) return 1'b1;
    slot = (t - fstart) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return fbyte[slot-1];
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    bit pop;
    if (!r) begin
      q.delete();
      act  = 1'b0;
      movf = 1'b0;
    end else begin
      pop = !in_frame() && (q.size() != 0);
      if (pop) begin
        fbyte  = q.pop_front();
        act    = 1'b1;
        fstart = t + 1;
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else movf = 1'b1;
      end
    end
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, t);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance both
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    reset_n   = r;
    char_vld  = v;
    char_data = d;
    if (chk_en) begin
      chk("uart_tx", 32'(uart_tx), 32'(m_tx()));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    end
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    model_step(r, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!m_busy()) begin
        done = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 8'h00);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    bit found;
    int zeros;
    int gap;
    int blen;

    reset_n   = 1'b0;
    char_vld  = 1'b0;
    char_data = 8'h00;
    #1;

    // 1. Reset held for three cycles
    cycle(1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    cycle(1'b0, 1'b1, 8'h55);
    cycle(1'b0, 1'b0, 8'h00);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // 2. Single character 0x41
    cycle(1'b1, 1'b1, 8'h41);
    drain("t2_drain");

    // 3. Burst "3f "
    cycle(1'b1, 1'b1, 8'h33);
    cycle(1'b1, 1'b1, 8'h66);
    cycle(1'b1, 1'b1, 8'h20);
    drain("t3_drain");
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Random bursts of 1..3 chars with random gaps
    for (int k = 0; k < 12; k++) begin
      blen = int'($urandom_range(1, 3));
      for (int j = 0; j < blen; j++) cycle(1'b1, 1'b1, 8'($urandom));
      gap = int'($urandom_range(0, 60));
      for (int j = 0; j < gap; j++) cycle(1'b1, 1'b0, 8'h00);
    end
    drain("rand_drain");

    // 4. Six consecutive chars: the sixth is dropped
    peak = 0;
    for (int j = 0; j < 6; j++) cycle(1'b1, 1'b1, 8'($urandom));
    drain("t4_drain");
    chk("t4_peak", 32'(peak), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd1);

    // 6. Full FIFO with write and pop in the same IDLE cycle
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'($urandom));
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b1, 8'($urandom));
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!in_frame() && q.size() == DEPTH) begin
        found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 8'h00);
    end
    chk("t6_reach_idle_full", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 8'($urandom));
    chk("t6_level", 32'(fifo_level), 32'd4);
    chk("t6_ovf", 32'(overflow), 32'd0);
    drain("t6_drain");

    // 5. Reset during data bit 3 with two chars queued
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 1'b1, 8'h3C);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_frame() && (t - fstart) == 4 * CPB) begin
        found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 8'h00);
    end
    chk("t5_reach_bit3", 32'(found), 32'd1);
    chk("t5_level_before", 32'(fifo_level), 32'd2);
    cycle(1'b0, 1'b0, 8'h00);
    chk("t5_tx_after_rst", 32'(uart_tx), 32'd1);
    chk("t5_level_after_rst", 32'(fifo_level), 32'd0);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      if (uart_tx !== 1'b1) zeros++;
      cycle(1'b1, 1'b0, 8'h00);
    end
    chk("t5_no_frames", 32'(zeros), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
